// File: rtl/universal_shift_register_if.sv
// Bus bundle for universal_shift_register: control and data in, register view out.
// The controller drives the master side and the register is the slave.
interface universal_shift_register_if #(
   parameter int WIDTH = 6
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             preset;
   logic [2:0]       mode;
   logic             sil;
   logic             sir;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qnot;
   logic             sol;
   logic             sor;
   logic [CW-1:0]    count;
   logic             done;

   modport master (
      output preset, mode, sil, sir, d,
      input  q, qnot, sol, sor, count, done
   );

   modport slave (
      input  preset, mode, sil, sir, d,
      output q, qnot, sol, sor, count, done
   );
endinterface

// File: rtl/universal_shift_register.sv
// Parametrised shift/rotate/load register that counts shifts since the last
// load and pulses done once when WIDTH shifts have been made.
module universal_shift_register #(
   parameter int               WIDTH      = 6,
   parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
   input logic                      clk,
   input logic                      clr,
   universal_shift_register_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_PRE = CW'(WIDTH - 1);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_ROTL = 3'b011;
   localparam logic [2:0] MODE_ROTR = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;

   logic [WIDTH-1:0] q_reg;
   logic [CW-1:0]    count_reg;
   logic             done_reg;
   logic             shifting;

   assign shifting = (bus.mode == MODE_SHL)  || (bus.mode == MODE_SHR) ||
                     (bus.mode == MODE_ROTL) || (bus.mode == MODE_ROTR) ||
                     (bus.mode == MODE_ASR);

   always_ff @(posedge clk) begin
      if (!clr) begin
         q_reg     <= '0;
         count_reg <= '0;
         done_reg  <= 1'b0;
      end else if (bus.preset) begin
         q_reg     <= PRESET_VAL;
         count_reg <= '0;
         done_reg  <= 1'b0;
      end else begin
         case (bus.mode)
            MODE_SHL:  q_reg <= {q_reg[WIDTH-2:0], bus.sil};
            MODE_SHR:  q_reg <= {bus.sir, q_reg[WIDTH-1:1]};
            MODE_ROTL: q_reg <= {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
            MODE_ROTR: q_reg <= {q_reg[0], q_reg[WIDTH-1:1]};
            MODE_LOAD: q_reg <= bus.d;
            MODE_ASR:  q_reg <= {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
            default:   q_reg <= q_reg;
         endcase

         if (bus.mode == MODE_LOAD)
            count_reg <= '0;
         else if (shifting && (count_reg < CNT_MAX))
            count_reg <= count_reg + 1'b1;

         // Pulse only on the edge that crosses WIDTH-1 -> WIDTH; saturation keeps it low.
         done_reg <= shifting && (count_reg == CNT_PRE);
      end
   end

   assign bus.q     = q_reg;
   assign bus.qnot  = ~q_reg;
   assign bus.sol   = q_reg[WIDTH-1];
   assign bus.sor   = q_reg[0];
   assign bus.count = count_reg;
   assign bus.done  = done_reg;
endmodule

// File: tb/tb_universal_shift_register.sv
// Directed-vector bench for universal_shift_register at WIDTH=6.
module tb_universal_shift_register;
   localparam int WIDTH = 6;

   logic clk;
   logic clr;
   int   checks;
   int   errors;

   universal_shift_register_if #(.WIDTH(WIDTH)) bus ();

   universal_shift_register #(.WIDTH(WIDTH), .PRESET_VAL(6'b111111)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b0; bus.preset = 1'b1; bus.mode = 3'b101; bus.d = 6'b101010;
      bus.sil = 1'b1; bus.sir = 1'b1;
      step();
      checks++;
      if (bus.q !== 6'b000000) begin errors++; $display("FAIL reset_q got %b want 000000", bus.q); end
      checks++;
      if (bus.qnot !== 6'b111111) begin errors++; $display("FAIL reset_qnot got %b want 111111", bus.qnot); end
      checks++;
      if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
   endtask

   task automatic test_deserialise();
      logic [5:0] sil_v;
      logic [5:0] exp_q [6];
      sil_v = 6'b001101;
      exp_q = '{6'b111111, 6'b111110, 6'b111101, 6'b111011, 6'b110110, 6'b101100};
      clr = 1'b1; bus.preset = 1'b1; bus.mode = 3'b000;
      step();
      checks++;
      if (bus.q !== 6'b111111 || bus.count !== 3'd0)
         begin errors++; $display("FAIL preset q=%b count=%0d want 111111/0", bus.q, bus.count); end
      bus.preset = 1'b0; bus.mode = 3'b001;
      for (int i = 0; i < 6; i++) begin
         bus.sil = sil_v[i];
         step();
         checks++;
         if (bus.q !== exp_q[i])
            begin errors++; $display("FAIL shl_q[%0d] got %b want %b", i, bus.q, exp_q[i]); end
         checks++;
         if (bus.count !== 3'(i + 1))
            begin errors++; $display("FAIL shl_count[%0d] got %0d want %0d", i, bus.count, i + 1); end
         checks++;
         if (bus.done !== (i == 5))
            begin errors++; $display("FAIL shl_done[%0d] got %b want %b", i, bus.done, i == 5); end
         checks++;
         if (bus.sol !== exp_q[i][5] || bus.sor !== exp_q[i][0])
            begin errors++; $display("FAIL shl_serial[%0d] sol=%b sor=%b want %b %b", i, bus.sol, bus.sor, exp_q[i][5], exp_q[i][0]); end
      end
   endtask

   task automatic test_rotate();
      bus.mode = 3'b101; bus.d = 6'b100001;
      step();
      checks++;
      if (bus.q !== 6'b100001 || bus.count !== 3'd0 || bus.done !== 1'b0)
         begin errors++; $display("FAIL load q=%b count=%0d done=%b want 100001/0/0", bus.q, bus.count, bus.done); end
      bus.mode = 3'b011;
      step();
      checks++;
      if (bus.q !== 6'b000011) begin errors++; $display("FAIL rotl got %b want 000011", bus.q); end
      bus.mode = 3'b100;
      step();
      checks++;
      if (bus.q !== 6'b100001) begin errors++; $display("FAIL rotr1 got %b want 100001", bus.q); end
      step();
      checks++;
      if (bus.q !== 6'b110000) begin errors++; $display("FAIL rotr2 got %b want 110000", bus.q); end
      checks++;
      if (bus.count !== 3'd3) begin errors++; $display("FAIL rot_count got %0d want 3", bus.count); end
   endtask

   task automatic test_asr();
      bus.mode = 3'b101; bus.d = 6'b100100;
      step();
      bus.mode = 3'b110;
      step();
      checks++;
      if (bus.q !== 6'b110010) begin errors++; $display("FAIL asr1 got %b want 110010", bus.q); end
      step();
      checks++;
      if (bus.q !== 6'b111001) begin errors++; $display("FAIL asr2 got %b want 111001", bus.q); end
      bus.mode = 3'b010; bus.sir = 1'b0;
      step();
      checks++;
      if (bus.q !== 6'b011100) begin errors++; $display("FAIL shr got %b want 011100", bus.q); end
      checks++;
      if (bus.count !== 3'd3) begin errors++; $display("FAIL asr_count got %0d want 3", bus.count); end
   endtask

   task automatic test_saturation();
      logic [5:0] exp_q [8];
      int         done_seen;
      exp_q = '{6'b010101, 6'b101011, 6'b010111, 6'b101111,
                6'b011111, 6'b111111, 6'b111111, 6'b111111};
      done_seen = 0;
      bus.mode = 3'b101; bus.d = 6'b101010;
      step();
      bus.mode = 3'b001; bus.sil = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.done === 1'b1) done_seen++;
         checks++;
         if (bus.q !== exp_q[i])
            begin errors++; $display("FAIL sat_q[%0d] got %b want %b", i, bus.q, exp_q[i]); end
         checks++;
         if (bus.count !== ((i < 5) ? 3'(i + 1) : 3'd6))
            begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", i, bus.count, (i < 5) ? i + 1 : 6); end
      end
      checks++;
      if (done_seen != 1) begin errors++; $display("FAIL sat_done_pulses got %0d want 1", done_seen); end
      bus.mode = 3'b000;
      step();
      checks++;
      if (bus.q !== 6'b111111 || bus.count !== 3'd6 || bus.done !== 1'b0)
         begin errors++; $display("FAIL hold q=%b count=%0d done=%b want 111111/6/0", bus.q, bus.count, bus.done); end
      bus.mode = 3'b111;
      step();
      checks++;
      if (bus.q !== 6'b111111 || bus.count !== 3'd6 || bus.done !== 1'b0)
         begin errors++; $display("FAIL reserved q=%b count=%0d done=%b want 111111/6/0", bus.q, bus.count, bus.done); end
   endtask

   task automatic test_serialise();
      logic [5:0] word;
      word = 6'b101101;
      bus.mode = 3'b101; bus.d = word;
      step();
      bus.mode = 3'b001; bus.sil = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (bus.sol !== word[5 - i])
            begin errors++; $display("FAIL ser_sol[%0d] got %b want %b", i, bus.sol, word[5 - i]); end
         step();
      end
      checks++;
      if (bus.q !== 6'b000000 || bus.done !== 1'b1)
         begin errors++; $display("FAIL ser_end q=%b done=%b want 000000/1", bus.q, bus.done); end
   endtask

   task automatic test_simultaneous();
      logic [5:0] exp_q [5];
      exp_q = '{6'b111110, 6'b111100, 6'b111000, 6'b110000, 6'b100000};
      bus.preset = 1'b1; bus.mode = 3'b001; bus.sil = 1'b0;
      step();
      checks++;
      if (bus.q !== 6'b111111 || bus.count !== 3'd0)
         begin errors++; $display("FAIL preset_vs_shl q=%b count=%0d want 111111/0", bus.q, bus.count); end
      bus.preset = 1'b0;
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (bus.q !== exp_q[4] || bus.count !== 3'd5)
         begin errors++; $display("FAIL pre_boundary q=%b count=%0d want 100000/5", bus.q, bus.count); end
      // Load on the edge that would have saturated the counter.
      bus.mode = 3'b101; bus.d = 6'b010101;
      step();
      checks++;
      if (bus.q !== 6'b010101 || bus.count !== 3'd0 || bus.done !== 1'b0)
         begin errors++; $display("FAIL load_boundary q=%b count=%0d done=%b want 010101/0/0", bus.q, bus.count, bus.done); end
      bus.mode = 3'b001; bus.sil = 1'b1;
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (bus.count !== 3'd5) begin errors++; $display("FAIL pre_clr count got %0d want 5", bus.count); end
      clr = 1'b0;
      step();
      checks++;
      if (bus.q !== 6'b000000 || bus.count !== 3'd0 || bus.done !== 1'b0)
         begin errors++; $display("FAIL clr_mid q=%b count=%0d done=%b want 000000/0/0", bus.q, bus.count, bus.done); end
      clr = 1'b1; bus.mode = 3'b000;
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.count !== 3'd0 || bus.q !== 6'b000000)
         begin errors++; $display("FAIL clr_after q=%b count=%0d done=%b want 000000/0/0", bus.q, bus.count, bus.done); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clr = 1'b0; bus.preset = 1'b0; bus.mode = 3'b000;
      bus.sil = 1'b0; bus.sir = 1'b0; bus.d = '0;
      #1;
      test_reset();
      test_deserialise();
      test_rotate();
      test_asr();
      test_saturation();
      test_serialise();
      test_simultaneous();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

- Parametrised successor to the fixed 6-bit preset left-shift register built from `dff` cells.
- Adds:
  - configurable width;
  - left and right shift, rotate and arithmetic-right modes;
  - parallel load;
  - independent serial inputs and outputs;
  - a shift counter with a completion pulse, so the block can serialise or deserialise a WIDTH-bit word.
- Used as the shared register primitive in the lab designs (serial I/O, bit-serial arithmetic, pattern generators).

## Interface
- `WIDTH`, 6, register width in bits (≥ 2).
- `PRESET_VAL`, {WIDTH{1'b1}}, value loaded by `preset`.
- `CW` (localparam), $clog2(WIDTH+1), counter width.

- `clk`  in  1  clock, all state updates on rising edge.
- `clr`  in  1  reset; one clock; reset is synchronous and active-low.
- `preset`  in  1  synchronous, active-high; loads `PRESET_VAL`.
- `mode`  in  3  operation select (see Operation).
- `sil`  in  1  serial input for left shift (enters bit 0).
- `sir`  in  1  serial input for right shift (enters bit WIDTH-1).
- `d`  in  WIDTH  parallel load data.
- `q`  out  WIDTH  register contents.
- `qnot`  out  WIDTH  bitwise complement of `q`.
- `sol`  out  1  serial out left = q[WIDTH-1].
- `sor`  out  1  serial out right = q[0].
- `count`  out  CW  shifts since last load/preset/reset, saturating at WIDTH.
- `done`  out  1  one-cycle pulse when `count` reaches WIDTH.

## Operation
- Priority per edge: `clr`=0 > `preset`=1 > `mode`.
- `clr`=0:
  - q=0, qnot=all ones, count=0, done=0.
  - Overrides `preset` and `mode`.
- `preset`=1:
  - q=PRESET_VAL, count=0, done=0.
- `mode` encoding:
  - 000 hold: q, count unchanged.
  - 001 shl: q <= {q[WIDTH-2:0], sil}.
  - 010 shr: q <= {sir, q[WIDTH-1:1]}.
  - 011 rotl: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 100 rotr: q <= {q[0], q[WIDTH-1:1]}.
  - 101 load: q <= d, count <= 0.
  - 110 asr: q <= {q[WIDTH-1], q[WIDTH-1:1]}.
  - 111 reserved: behaves as hold.
- Counter:
  - Modes 001/010/011/100/110 increment `count` if count < WIDTH; otherwise it stays at WIDTH.
  - Shifting continues after saturation.
- `done`:
  - Registered; =1 for exactly the cycle following the edge on which count goes WIDTH-1 → WIDTH.
  - Deasserted by any other edge.
  - No re-pulse until count is cleared by load, preset or reset.
- `qnot`, `sol` and `sor` are combinational from `q`; they carry no independent state.
- X on `sil`/`sir` propagates into `q` only in the mode that consumes it.

## Timing
- Single clock domain; no combinational path from inputs to outputs.
- `q`, `count` and `done` all change only at the rising edge of `clk`.
- Latency: one clock from mode/data sample to updated `q`.
- `done` is visible in the same cycle that `count` reads WIDTH.
- Deserialise: WIDTH shl/shr edges after load/preset → full word in `q`, `done`=1.
- Serialise: load, then WIDTH shifts; `sol`/`sor` present each bit one cycle apart, first bit valid immediately after load.
- Reset mid-operation:
  - Next edge with `clr`=0 discards the shift in progress.
  - Any `done` pulse due on that edge is suppressed.
- Load or preset on the edge where count would hit WIDTH: load/preset wins, count=0, done=0.
- Mode change between cycles is allowed every cycle and needs no idle cycle.

## Test plan
- Reset with preset=1 and mode=101 (clr=0) → q=000000, qnot=111111, count=0, done=0.
- WIDTH=6, preset, then shl with sil=1,0,1,1,0,0:
  - q=111111 → 111110 → 111101 → 111011 → 110110 → 101100;
  - count 1..6;
  - done=1 only after 6th edge.
- load d=100001, rotl ×1 → 000011, rotr ×2 → 100001 → 110000, count=3.
- load 100100, asr ×2 → 110010 → 111001; then shr with sir=0 → 011100.
- Saturation: 8 shl edges after load → count stays 6, done pulses once; hold (000) and reserved (111) leave q and count unchanged.
- Simultaneous events:
  - preset=1 with mode=001 → q=PRESET_VAL, count=0.
  - clr=0 at count=5 during shl → q=0, count=0, no done on the following edge.
